// File: rtl/rotary_encoder_emulator_pkg.sv
// Shared definitions for the rotary encoder emulator: FSM state encoding, the
// detent level and the right/left quadrature sequences. A decoder bench may
// import the same package to use the sequences as its reference model.
package rotary_encoder_emulator_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBounce = 2'd1,
        StHold   = 2'd2
    } state_e;

    // {A, B} level at rest between detents
    localparam logic [1:0] DetentLevel = 2'b11;

    // Settled {A, B} level after quarter 0..3, quarter 0 in the top bits
    localparam logic [7:0] SeqRight = {2'b01, 2'b00, 2'b10, 2'b11};
    localparam logic [7:0] SeqLeft  = {2'b10, 2'b00, 2'b01, 2'b11};

    // Settled level reached at the end of the given quarter transition
    function automatic logic [1:0] quad_level(input logic left, input logic [1:0] quarter);
        logic [7:0] seq;
        logic [1:0] lvl;
        seq = left ? SeqLeft : SeqRight;
        unique case (quarter)
            2'd0:    lvl = seq[7:6];
            2'd1:    lvl = seq[5:4];
            2'd2:    lvl = seq[3:2];
            default: lvl = seq[1:0];
        endcase
        return lvl;
    endfunction

    // Level in force before the given quarter transition starts
    function automatic logic [1:0] quad_prev(input logic left, input logic [1:0] quarter);
        return (quarter == 2'd0) ? DetentLevel : quad_level(left, quarter - 2'd1);
    endfunction

endpackage

// File: rtl/rotary_encoder_emulator_if.sv
// Command and waveform bundle between a step source (master) and the rotary
// encoder emulator (slave).
//   step_valid/step_left/bounce_en : step command, held until step_ready
//   step_ready                     : emulator idle
//   rotary_A/rotary_B              : quadrature outputs
//   position                       : signed net completed steps
interface rotary_encoder_emulator_if #(
    parameter int unsigned POS_WIDTH = 16
) ();

    logic                 step_valid;
    logic                 step_left;
    logic                 bounce_en;
    logic                 step_ready;
    logic                 rotary_A;
    logic                 rotary_B;
    logic [POS_WIDTH-1:0] position;

    modport master (
        output step_valid,
        output step_left,
        output bounce_en,
        input  step_ready,
        input  rotary_A,
        input  rotary_B,
        input  position
    );

    modport slave (
        input  step_valid,
        input  step_left,
        input  bounce_en,
        output step_ready,
        output rotary_A,
        output rotary_B,
        output position
    );

endinterface

// File: rtl/rotary_phase_timer.sv
// Down-counting interval timer shared by the bounce and hold intervals.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : start a new interval of len_i clocks (len_i >= 1)
//   en_i          : count while high
//   done_o        : high in the last clock of the interval; the owner acts on
//                   the edge that ends it and normally reloads in the same cycle
module rotary_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] len_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            // Load len-1 so that done lands exactly len edges after the load
            cnt_d = len_i - WIDTH'(1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Not a function of load_i, which itself depends on done_o
    assign done_o = en_i && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rotary_encoder_emulator.sv
// Emulates a detented mechanical rotary encoder. Each accepted step command
// plays one full quadrature cycle (four quarter transitions) on rotary_A/B,
// optionally with deterministic contact bounce on the changing line, then
// updates the signed position counter.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : step command in, quadrature/position/ready out (slave modport)
module rotary_encoder_emulator
    import rotary_encoder_emulator_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES  = 1000,
    parameter int unsigned BOUNCE_PAIRS  = 2,
    parameter int unsigned BOUNCE_CYCLES = 20,
    parameter int unsigned POS_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rotary_encoder_emulator_if.slave bus
);

    localparam int unsigned MaxInterval =
        (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxInterval) + 1;
    localparam int unsigned TogW   = $clog2(2 * BOUNCE_PAIRS + 2);

    localparam logic [TimerW-1:0] PhaseLen  = TimerW'(PHASE_CYCLES);
    localparam logic [TimerW-1:0] BounceLen = TimerW'(BOUNCE_CYCLES);
    localparam logic [TogW-1:0]   TogTotal  = TogW'(2 * BOUNCE_PAIRS);

    state_e               state_q, state_d;
    logic [1:0]           quarter_q, quarter_d;
    logic [TogW-1:0]      tog_q, tog_d;
    logic [1:0]           level_q, level_d;   // {A, B}
    logic                 ready_q, ready_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 left_q, left_d;
    logic                 bounce_q, bounce_d;

    logic                 tmr_load;
    logic [TimerW-1:0]    tmr_len;
    logic                 tmr_done;

    // Transition launch request, shared by command accept and quarter advance
    logic                 start;
    logic                 start_left;
    logic                 start_bounce;
    logic [1:0]           start_quarter;

    rotary_phase_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (tmr_load),
        .len_i  (tmr_len),
        .en_i   (state_q != StIdle),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        quarter_d     = quarter_q;
        tog_d         = tog_q;
        level_d       = level_q;
        ready_d       = ready_q;
        pos_d         = pos_q;
        left_d        = left_q;
        bounce_d      = bounce_q;
        tmr_load      = 1'b0;
        tmr_len       = PhaseLen;
        start         = 1'b0;
        start_left    = left_q;
        start_bounce  = bounce_q;
        start_quarter = quarter_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (ready_q && bus.step_valid) begin
                    ready_d       = 1'b0;
                    left_d        = bus.step_left;
                    bounce_d      = bus.bounce_en;
                    quarter_d     = 2'd0;
                    start         = 1'b1;
                    start_left    = bus.step_left;
                    start_bounce  = bus.bounce_en;
                    start_quarter = 2'd0;
                end
            end

            StBounce: begin
                if (tmr_done) begin
                    // Flip only the line this quarter moves
                    level_d  = level_q ^ (quad_level(left_q, quarter_q) ^
                                          quad_prev(left_q, quarter_q));
                    tog_d    = tog_q - TogW'(1);
                    tmr_load = 1'b1;
                    if (tog_q == TogW'(1)) begin
                        state_d = StHold;
                        tmr_len = PhaseLen;
                    end else begin
                        tmr_len = BounceLen;
                    end
                end
            end

            StHold: begin
                if (tmr_done) begin
                    if (quarter_q == 2'd3) begin
                        state_d = StIdle;
                        ready_d = 1'b1;
                        pos_d   = left_q ? pos_q - POS_WIDTH'(1) : pos_q + POS_WIDTH'(1);
                    end else begin
                        quarter_d     = quarter_q + 2'd1;
                        start         = 1'b1;
                        start_quarter = quarter_q + 2'd1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        if (start) begin
            level_d  = quad_level(start_left, start_quarter);
            tmr_load = 1'b1;
            if (start_bounce && (BOUNCE_PAIRS > 0)) begin
                state_d = StBounce;
                tog_d   = TogTotal;
                tmr_len = BounceLen;
            end else begin
                state_d = StHold;
                tmr_len = PhaseLen;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            quarter_q <= 2'd0;
            tog_q     <= '0;
            level_q   <= DetentLevel;
            ready_q   <= 1'b0;
            pos_q     <= '0;
            left_q    <= 1'b0;
            bounce_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            tog_q     <= tog_d;
            level_q   <= level_d;
            ready_q   <= ready_d;
            pos_q     <= pos_d;
            left_q    <= left_d;
            bounce_q  <= bounce_d;
        end
    end

    assign bus.step_ready = ready_q;
    assign bus.rotary_A   = level_q[1];
    assign bus.rotary_B   = level_q[0];
    assign bus.position   = pos_q;

endmodule
